// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback over one
// shared memory port, with a memready handshake, BNE/JAL, illegal-op detection and halt.
module mips_mc_controller #(
    parameter bit WAIT_EN      = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcwrite,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       signext,
    output logic       shiftl16,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_JAL    = 4'd12, S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    state_t state_reg, state_next;
    logic   rdy;
    logic   funct_legal;
    logic   pc_we, ir_we, reg_we, mem_rd, mem_wr;

    assign rdy   = WAIT_EN ? memready : 1'b1;
    assign state = state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        case (funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                         funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b010;
        pcsrc      = 2'b00;
        signext    = 1'b0;
        shiftl16   = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_rd  = 1'b1;
                alusrcb = 2'b01;
                ir_we   = rdy;
                pc_we   = rdy;
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                signext = 1'b1;
                case (op)
                    OP_LW, OP_SW:                      state_next = S_MEMADR;
                    OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_next = S_IEXEC;
                    OP_J:                              state_next = S_JUMP;
                    OP_JAL:                            state_next = S_JAL;
                    OP_RTYPE: begin
                        if (funct_legal) state_next = S_EXEC;
                        else             illegal    = 1'b1;
                    end
                    default:                           illegal    = 1'b1;
                endcase
                if (illegal) state_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                signext    = 1'b1;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (rdy) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                memtoreg   = 2'b01;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (rdy) state_next = S_FETCH;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010, 6'b100011: alucontrol = 3'b110;
                    6'b100100:            alucontrol = 3'b000;
                    6'b100101:            alucontrol = 3'b001;
                    6'b101010:            alucontrol = 3'b111;
                    default:              alucontrol = 3'b010;
                endcase
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                regdst     = 2'b01;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pc_we      = (op == OP_BNE) ? ~zero : zero;
                state_next = S_FETCH;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ORI:  alucontrol = 3'b001;
                    OP_LUI:  shiftl16   = 1'b1;
                    default: signext    = 1'b1;
                endcase
                state_next = S_IWB;
            end
            S_IWB: begin
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pc_we      = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so the link value comes straight from PC
                pcsrc      = 2'b10;
                pc_we      = 1'b1;
                reg_we     = 1'b1;
                regdst     = 2'b10;
                memtoreg   = 2'b10;
                state_next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes are suppressed for the whole time reset is held, not just at the edge
    assign pcwrite  = pc_we  & ~reset;
    assign irwrite  = ir_we  & ~reset;
    assign regwrite = reg_we & ~reset;
    assign memread  = mem_rd & ~reset;
    assign memwrite = mem_wr & ~reset;

endmodule
